// File: rtl/a1335_i2c_responder_if.sv
// Host-side signals of the A1335 responder.
// Carries address/angle/status configuration in and write/read events out.
interface a1335_i2c_responder_if;
    logic [6:0]  device_id;
    logic [11:0] angle;
    logic [3:0]  status_flags;
    logic        busy;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        angle_read;

    modport slave (
        input  device_id, angle, status_flags,
        output busy, wr_strobe, wr_addr, wr_data, angle_read
    );

    modport master (
        output device_id, angle, status_flags,
        input  busy, wr_strobe, wr_addr, wr_data, angle_read
    );
endinterface

// File: rtl/a1335_i2c_responder.sv
// I2C target emulating an A1335 angle sensor: registers 0x20/0x21 hold a per-read snapshot of status/angle.
// Optional macro A1335_RESPONDER_GLITCH_FILTER_EN adds a 3-sample majority filter on scl/sda.
module a1335_i2c_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        scl,
    inout  wire                         sda,
    a1335_i2c_responder_if.slave        host
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
    logic sclIn, sdaIn;
    logic sclPrev_q, sdaPrev_q;

    // Synchronizers reset to the idle (pulled-up) bus level
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda};
        end
    end

`ifdef A1335_RESPONDER_GLITCH_FILTER_EN
    logic [1:0] sclHist_q, sdaHist_q;
    logic       sclFilt_q, sdaFilt_q;
    logic       sclS, sdaS;

    assign sclS = sclSync_q[SYNC_STAGES-1];
    assign sdaS = sdaSync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sclHist_q <= '1;
            sdaHist_q <= '1;
            sclFilt_q <= 1'b1;
            sdaFilt_q <= 1'b1;
        end else begin
            sclHist_q <= {sclHist_q[0], sclS};
            sdaHist_q <= {sdaHist_q[0], sdaS};
            sclFilt_q <= (sclS & sclHist_q[0]) | (sclS & sclHist_q[1]) | (sclHist_q[0] & sclHist_q[1]);
            sdaFilt_q <= (sdaS & sdaHist_q[0]) | (sdaS & sdaHist_q[1]) | (sdaHist_q[0] & sdaHist_q[1]);
        end
    end

    assign sclIn = sclFilt_q;
    assign sdaIn = sdaFilt_q;
`else
    assign sclIn = sclSync_q[SYNC_STAGES-1];
    assign sdaIn = sdaSync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclPrev_q <= sclIn;
            sdaPrev_q <= sdaIn;
        end
    end

    logic sclRise, sclFall, startCond, stopCond;
    assign sclRise   = sclIn & ~sclPrev_q;
    assign sclFall   = ~sclIn & sclPrev_q;
    assign startCond = sclIn & sclPrev_q & sdaPrev_q & ~sdaIn;
    assign stopCond  = sclIn & sclPrev_q & ~sdaPrev_q & sdaIn;

    state_t      state_q, state_d;
    logic [3:0]  bitCnt_q, bitCnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [15:0] snap_q, snap_d;
    logic        firstByte_q, firstByte_d;
    logic        ackOn_q, ackOn_d;
    logic        nack_q, nack_d;
    logic        sdaLow_q, sdaLow_d;
    logic        busy_q, busy_d;
    logic        wrStrobe_q, wrStrobe_d;
    logic [7:0]  wrAddr_q, wrAddr_d;
    logic [7:0]  wrData_q, wrData_d;
    logic        angleRead_q, angleRead_d;

    function automatic logic [7:0] regByte(input logic [7:0] p, input logic [15:0] s);
        case (p)
            8'h20:   regByte = s[15:8];
            8'h21:   regByte = s[7:0];
            default: regByte = 8'h00;
        endcase
    endfunction

    logic [7:0] curByte, nextByte, inByte;
    assign curByte  = regByte(ptr_q, snap_q);
    assign nextByte = regByte(ptr_q + 8'd1, snap_q);
    assign inByte   = {shift_q[6:0], sdaIn};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            snap_q      <= '0;
            firstByte_q <= 1'b0;
            ackOn_q     <= 1'b0;
            nack_q      <= 1'b0;
            sdaLow_q    <= 1'b0;
            busy_q      <= 1'b0;
            wrStrobe_q  <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            angleRead_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            snap_q      <= snap_d;
            firstByte_q <= firstByte_d;
            ackOn_q     <= ackOn_d;
            nack_q      <= nack_d;
            sdaLow_q    <= sdaLow_d;
            busy_q      <= busy_d;
            wrStrobe_q  <= wrStrobe_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            angleRead_q <= angleRead_d;
        end
    end

    // sda only changes on synchronized scl falls, so it is stable for the whole high phase
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        snap_d      = snap_q;
        firstByte_d = firstByte_q;
        ackOn_d     = ackOn_q;
        nack_d      = nack_q;
        sdaLow_d    = sdaLow_q;
        busy_d      = busy_q;
        wrStrobe_d  = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        angleRead_d = 1'b0;

        if (stopCond) begin
            state_d  = IDLE;
            sdaLow_d = 1'b0;
            busy_d   = 1'b0;
        end else if (startCond) begin
            state_d  = ADDR;
            bitCnt_d = '0;
            ackOn_d  = 1'b0;
            sdaLow_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (sclRise) begin
                    shift_d  = inByte;
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd7) begin
                        bitCnt_d = '0;
                        if (shift_q[6:0] == host.device_id) begin
                            state_d     = ADDR_ACK;
                            busy_d      = 1'b1;
                            ackOn_d     = 1'b0;
                            firstByte_d = 1'b1;
                            if (sdaIn) snap_d = {host.status_flags, host.angle};
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK, WR_ACK: if (sclFall) begin
                    if (!ackOn_q) begin
                        sdaLow_d = 1'b1;
                        ackOn_d  = 1'b1;
                    end else begin
                        ackOn_d  = 1'b0;
                        bitCnt_d = '0;
                        if (state_q == ADDR_ACK && shift_q[0]) begin
                            shift_d  = curByte;
                            sdaLow_d = ~curByte[7];
                            state_d  = RD_BYTE;
                        end else begin
                            sdaLow_d = 1'b0;
                            state_d  = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: if (sclRise) begin
                    shift_d  = inByte;
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd7) begin
                        bitCnt_d = '0;
                        ackOn_d  = 1'b0;
                        state_d  = WR_ACK;
                        if (firstByte_q) begin
                            ptr_d       = inByte;
                            firstByte_d = 1'b0;
                        end else begin
                            wrStrobe_d = 1'b1;
                            wrAddr_d   = ptr_q;
                            wrData_d   = inByte;
                            ptr_d      = ptr_q + 8'd1;
                        end
                    end
                end
                RD_BYTE: begin
                    if (sclRise) bitCnt_d = bitCnt_q + 4'd1;
                    if (sclFall) begin
                        if (bitCnt_q == 4'd8) begin
                            sdaLow_d = 1'b0;
                            bitCnt_d = '0;
                            state_d  = RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sdaLow_d = ~shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (sclRise) begin
                        nack_d = sdaIn;
                        if (sdaIn) busy_d = 1'b0;
                    end
                    if (sclFall) begin
                        angleRead_d = (ptr_q == 8'h21);
                        ptr_d       = ptr_q + 8'd1;
                        if (nack_q) begin
                            state_d = IGNORE;
                        end else begin
                            shift_d  = nextByte;
                            sdaLow_d = ~nextByte[7];
                            state_d  = RD_BYTE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda             = sdaLow_q ? 1'b0 : 1'bz;
    assign host.busy       = busy_q;
    assign host.wr_strobe  = wrStrobe_q;
    assign host.wr_addr    = wrAddr_q;
    assign host.wr_data    = wrData_q;
    assign host.angle_read = angleRead_q;
endmodule

// File: doc/a1335_i2c_responder.md
# a1335_i2c_responder

I2C target (slave) that emulates an A1335 angle sensor on the bus driven by our I2C master, so the myo_control read path can be exercised in simulation and on hardware-in-the-loop rigs without a physical sensor. Decodes START/STOP, matches a 7-bit device address, keeps a byte register pointer, serves a snapshot of a host-supplied angle and status, and reports master writes to the host.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the scl/sda input synchronizers (min 2).
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- scl  input  1  bus clock from the master (open-drain, externally pulled up).
- sda  inout  1  bus data; driven only to 0, otherwise high-Z.
- device_id  input  7  bus address this responder answers.
- angle  input  12  current angle value from host.
- status_flags  input  4  flags returned in the angle register's upper nibble.
- busy  output  1  high from address ACK until STOP/START or mismatch.
- wr_strobe  output  1  one-cycle pulse per data byte written by the master.
- wr_addr  output  8  register pointer of the written byte (valid with wr_strobe).
- wr_data  output  8  written byte (valid with wr_strobe).
- angle_read  output  1  one-cycle pulse when byte 0x21 finishes transmitting.

## Operation
- scl/sda sampled through SYNC_STAGES flops; edges detected on synchronized values. START = sda falling while scl high; STOP = sda rising while scl high.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- IDLE: wait for START -> ADDR. START in any state -> ADDR (repeated start); STOP in any state -> IDLE, sda released.
- ADDR: shift 8 bits MSB first on scl rising edges. addr[7:1]==device_id -> ADDR_ACK, else IGNORE (no ACK, wait for START/STOP).
- ADDR_ACK: drive sda low for the 9th clock. R/W=0 -> WR_BYTE with first_byte=1; R/W=1 -> latch snapshot {status_flags, angle} then RD_BYTE.
- WR_BYTE/WR_ACK: after 8 bits, always ACK. first_byte: load pointer, no strobe. Otherwise pulse wr_strobe with wr_addr=pointer, wr_data=byte, then pointer+1.
- RD_BYTE: shift out byte at pointer, MSB first. Map: 0x20 = {status_flags, angle[11:8]} from snapshot; 0x21 = angle[7:0] from snapshot; all others 0x00. RD_ACK: sample master bit on 9th rising edge; ACK(0) -> pointer+1, next byte; NACK(1) -> release sda, IGNORE.
- Pointer is 8-bit, wraps 0xFF -> 0x00, retained across transactions (reset value 0x00).
- Snapshot taken once per read transaction, so 0x20/0x21 are coherent even if angle changes mid-read.

## Timing
- Reset values: sda released, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, angle_read=0, pointer=0x00, state IDLE.
- Input latency SYNC_STAGES+1 clocks from pin to edge detect; requires clock >= 16x scl frequency (50 MHz vs 400 kHz nominal).
- sda output changes only one clock after a synchronized scl falling edge; stable through the whole scl-high phase.
- ACK driven from falling edge after bit 8 to falling edge after bit 9.
- wr_strobe asserts one clock after the 8th scl rising edge of a data byte, exactly one cycle wide.
- angle_read pulses one clock after the falling edge ending the ACK/NACK slot of byte 0x21.
- busy rises on the ADDR_ACK entry, falls the clock after STOP/START detection or NACK.
- reset_n low mid-transfer: sda released on the next clock edge, all state cleared.

## Configuration
- A1335_RESPONDER_GLITCH_FILTER_EN: defined -> 3-sample majority filter after the synchronizers on scl and sda (adds 2 clocks latency, suppresses pulses <2 clocks). Undefined -> synchronizer output used directly.

## Test plan
- device_id=0x0C, master writes addr 0x18, byte 0x20, repeated start, reads 2 bytes with angle=0xABC, status_flags=0x5 -> returns 0x5A, 0xBC; angle_read pulses once.
- Master addresses 0x0D -> no ACK, busy stays 0, sda never driven until next START.
- Write 0x18, 0x10, 0x11, 0x22 -> wr_strobe twice: (0x10,0x11), (0x11,0x22); pointer ends 0x12.
- Pointer set to 0xFF, read 3 bytes -> 0x00, 0x00 then byte at 0x01 = 0x00; pointer wraps to 0x02.
- Change angle from 0x123 to 0x456 between bytes of one read -> 0x01, 0x23 returned (snapshot).
- reset_n low during RD_BYTE with sda driven low -> sda high-Z next clock, busy=0, pointer=0x00.
